// File: rtl/fetch_resp_buffer.sv
// Instruction-fetch response stage: tracks in-order ibus requests and TLB-fault fetches,
// queues returned instructions in a small FIFO for dual-issue decode, drops stale responses after flush.

module fetch_resp_slot (
  input  logic        vld,
  input  logic [31:0] ent_inst,
  input  logic [31:0] ent_pc,
  input  logic        ent_inv,
  input  logic        ent_ref,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        tlb_inv,
  output logic        tlb_ref
);
  // Invalid slots present zeros so downstream never sees stale FIFO contents.
  assign inst    = vld ? ent_inst : 32'b0;
  assign pc      = vld ? ent_pc   : 32'b0;
  assign tlb_inv = vld & ent_inv;
  assign tlb_ref = vld & ent_ref;
endmodule

module fetch_resp_buffer #(
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_fire,
  input  logic [31:0] req_pc,
  input  logic        fault_fire,
  input  logic        fault_refill,
  input  logic        data_ok,
  input  logic [63:0] rdata,
  output logic        req_allow,
  output logic [1:0]  out_valid,
  output logic [63:0] out_inst,
  output logic [63:0] out_pc,
  output logic [1:0]  out_tlb_inv,
  output logic [1:0]  out_tlb_ref,
  input  logic [1:0]  pop
);
  localparam int NUM_LANES = 2;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = CW + 1;
  localparam int QW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int QCW = $clog2(MAX_OUT + 1);
  localparam int DW  = $clog2(MAX_OUT + 1) + 1;
  localparam int SW  = CW + QCW + 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tlb_inv;
    logic        tlb_ref;
  } fifo_ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    logic        refill;
  } rq_ent_t;

  fifo_ent_t          fifo_mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      fifo_cnt;

  rq_ent_t            rq_mem [MAX_OUT];
  logic [MAX_OUT-1:0] rq_vld;
  logic [QW-1:0]      rq_rd, rq_wr;
  logic [QCW-1:0]     rq_cnt;
  logic [DW-1:0]      drop_cnt;

  rq_ent_t            rq_head, rq_new;
  logic               head_vld, bus_ret, fault_ret, rq_push, rq_pop, fault_in_rq;
  logic [1:0]         push_n;
  logic [QCW-1:0]     nonfault_cnt;
  fifo_ent_t          ent0, ent1;
  logic [SW-1:0]      credit_sum;
  logic [DW-1:0]      drop_flush;

  assign rq_head  = rq_mem[rq_rd];
  assign head_vld = rq_vld[rq_rd];
  assign rq_new   = '{pc: req_pc, fault: fault_fire, refill: fault_fire & fault_refill};

  always_comb begin
    bus_ret   = 1'b0;
    fault_ret = 1'b0;
    push_n    = 2'd0;
    ent0      = '0;
    ent1      = '0;
    // A fault entry retires as soon as it reaches the head; bus entries wait for
    // their response, and only once every stale response has been swallowed.
    if (head_vld && rq_head.fault) begin
      fault_ret = 1'b1;
      push_n    = 2'd1;
      ent0      = '{inst: 32'b0, pc: rq_head.pc, tlb_inv: ~rq_head.refill, tlb_ref: rq_head.refill};
    end else if (head_vld && data_ok && drop_cnt == '0) begin
      bus_ret = 1'b1;
      push_n  = 2'd2;
      ent0    = '{inst: rdata[31:0],  pc: rq_head.pc,         tlb_inv: 1'b0, tlb_ref: 1'b0};
      ent1    = '{inst: rdata[63:32], pc: rq_head.pc + 32'd4, tlb_inv: 1'b0, tlb_ref: 1'b0};
    end
    rq_pop  = bus_ret | fault_ret;
    rq_push = req_fire | fault_fire;
  end

  always_comb begin
    nonfault_cnt = '0;
    fault_in_rq  = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      nonfault_cnt = nonfault_cnt + QCW'(rq_vld[i] & ~rq_mem[i].fault);
      fault_in_rq  = fault_in_rq | (rq_vld[i] & rq_mem[i].fault);
    end
  end

  // Every queued request reserves two FIFO slots, so responses can always land.
  assign credit_sum = SW'(fifo_cnt) + (SW'(rq_cnt) << 1) + SW'(2);
  assign req_allow  = (rq_cnt < QCW'(MAX_OUT)) && !fault_in_rq && (credit_sum <= SW'(DEPTH));

  assign drop_flush = drop_cnt + DW'(nonfault_cnt) - DW'(data_ok) + DW'(req_fire);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      rq_vld   <= '0;
      rq_rd    <= '0;
      rq_wr    <= '0;
      rq_cnt   <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      rq_vld   <= '0;
      rq_rd    <= '0;
      rq_wr    <= '0;
      rq_cnt   <= '0;
      drop_cnt <= drop_flush;
    end else begin
      rd_ptr   <= rd_ptr + AW'(pop);
      wr_ptr   <= wr_ptr + AW'(push_n);
      fifo_cnt <= fifo_cnt + CW'(push_n) - CW'(pop);
      if (data_ok && drop_cnt != '0)
        drop_cnt <= drop_cnt - DW'(1);
      if (rq_pop) begin
        rq_vld[rq_rd] <= 1'b0;
        rq_rd         <= rq_rd + QW'(1);
      end
      if (rq_push) begin
        rq_vld[rq_wr] <= 1'b1;
        rq_wr         <= rq_wr + QW'(1);
      end
      rq_cnt <= rq_cnt + QCW'(rq_push) - QCW'(rq_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by pointers and valid bits.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) fifo_mem[wr_ptr] <= ent0;
    if (push_n == 2'd2) fifo_mem[wr_ptr + AW'(1)] <= ent1;
    if (rq_push)        rq_mem[rq_wr] <= rq_new;
  end

  always_comb begin
    out_valid = 2'b00;
    if (fifo_cnt == CW'(1))      out_valid = 2'b01;
    else if (fifo_cnt >= CW'(2)) out_valid = 2'b11;
  end

  generate
    for (genvar s = 0; s < NUM_LANES; s++) begin : g_slot
      logic [AW-1:0] idx;
      assign idx = rd_ptr + AW'(s);
      fetch_resp_slot u_slot (
        .vld      (out_valid[s]),
        .ent_inst (fifo_mem[idx].inst),
        .ent_pc   (fifo_mem[idx].pc),
        .ent_inv  (fifo_mem[idx].tlb_inv),
        .ent_ref  (fifo_mem[idx].tlb_ref),
        .inst     (out_inst[32*s +: 32]),
        .pc       (out_pc[32*s +: 32]),
        .tlb_inv  (out_tlb_inv[s]),
        .tlb_ref  (out_tlb_ref[s])
      );
    end
  endgenerate

`ifndef SYNTHESIS
  // Overflow or over-pop can only come from an upstream protocol violation.
  always @(posedge clk) begin
    if (reset && !flush) begin
      assert ({1'b0, fifo_cnt} + EW'(push_n) - EW'(pop) <= EW'(DEPTH));
      assert (CW'(pop) <= fifo_cnt);
      assert (!(req_fire && fault_fire));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_resp_buffer.sv
// Directed bench for fetch_resp_buffer: stimulus pushes expected FIFO entries into a
// scoreboard queue; a consumer process pops the DUT and compares in order.

module tb_fetch_resp_buffer;
  logic        clk, reset, flush, req_fire, fault_fire, fault_refill, data_ok;
  logic [31:0] req_pc;
  logic [63:0] rdata;
  logic        req_allow;
  logic [1:0]  out_valid, out_tlb_inv, out_tlb_ref, pop;
  logic [63:0] out_inst, out_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inv;
    logic        rf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   max_fifo = 0;
  logic pop_en = 1'b0;

  fetch_resp_buffer #(.DEPTH(8), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_fire(req_fire), .req_pc(req_pc),
    .fault_fire(fault_fire), .fault_refill(fault_refill), .data_ok(data_ok), .rdata(rdata),
    .req_allow(req_allow), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_tlb_inv(out_tlb_inv), .out_tlb_ref(out_tlb_ref), .pop(pop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[23:0], 8'h5A};
  endfunction

  // Consumer: pops whatever is valid (when enabled) and checks each entry in order.
  initial begin
    int   n;
    exp_t act, e;
    pop = 2'd0;
    forever begin
      @(negedge clk);
      #1;
      if (int'(dut.fifo_cnt) > max_fifo) max_fifo = int'(dut.fifo_cnt);
      n = (out_valid == 2'b11) ? 2 : (out_valid == 2'b01) ? 1 : 0;
      if (!pop_en) n = 0;
      for (int i = 0; i < n; i++) begin
        act = '{pc: out_pc[32*i +: 32], inst: out_inst[32*i +: 32],
                inv: out_tlb_inv[i], rf: out_tlb_ref[i]};
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_entry: got pc=%h inst=%h with nothing expected", act.pc, act.inst);
        end else begin
          e = exp_q.pop_front();
          chk("entry", 128'(act), 128'(e));
        end
      end
      pop = 2'(n);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] pc);
    req_fire = 1'b1;
    req_pc   = pc;
    tick();
    req_fire = 1'b0;
  endtask

  task automatic exp_pair(input logic [31:0] pc);
    exp_q.push_back('{pc: pc,         inst: inst_of(pc),         inv: 1'b0, rf: 1'b0});
    exp_q.push_back('{pc: pc + 32'd4, inst: inst_of(pc + 32'd4), inv: 1'b0, rf: 1'b0});
  endtask

  // Response for pc; expect_out=0 for a response that must be dropped.
  task automatic resp(input logic [31:0] pc, input bit expect_out);
    data_ok = 1'b1;
    rdata   = {inst_of(pc + 32'd4), inst_of(pc)};
    if (expect_out) exp_pair(pc);
    tick();
    data_ok = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid != 2'b00); i++) tick();
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_fire = 1'b0; fault_fire = 1'b0; fault_refill = 1'b0;
    data_ok = 1'b0; req_pc = '0; rdata = '0;
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_inst",  128'(out_inst),  128'(0));
    chk("rst_out_pc",    128'(out_pc),    128'(0));
    chk("rst_out_tlb",   128'({out_tlb_inv, out_tlb_ref}), 128'(0));
    chk("rst_req_allow", 128'(req_allow), 128'(1));
    reset = 1'b1;
    tick();

    // 1: single request, explicit instruction words
    pop_en = 1'b0;
    req(32'hBFC0_0000);
    tick();
    data_ok = 1'b1;
    rdata   = {32'h2508_0010, 32'h3C08_BFC0};
    exp_q.push_back('{pc: 32'hBFC0_0000, inst: 32'h3C08_BFC0, inv: 1'b0, rf: 1'b0});
    exp_q.push_back('{pc: 32'hBFC0_0004, inst: 32'h2508_0010, inv: 1'b0, rf: 1'b0});
    tick();
    data_ok = 1'b0;
    chk("t1_valid", 128'(out_valid), 128'(2'b11));
    chk("t1_pc",    128'(out_pc),    128'(64'hBFC0_0004_BFC0_0000));
    chk("t1_inst",  128'(out_inst),  128'(64'h2508_0010_3C08_BFC0));
    pop_en = 1'b1;
    drain("t1_drain");

    // 2: back-to-back requests, credit closes at two outstanding
    req(32'h0001_0000);
    chk("t2_allow_one", 128'(req_allow), 128'(1));
    req(32'h0001_0008);
    chk("t2_allow_full", 128'(req_allow), 128'(0));
    resp(32'h0001_0000, 1'b1);
    chk("t2_allow_reopen", 128'(req_allow), 128'(1));
    resp(32'h0001_0008, 1'b1);
    drain("t2_drain");

    // 3: flush with two outstanding, then a fresh request
    req(32'h0002_0000);
    req(32'h0002_0008);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_drop2",  128'(dut.drop_cnt), 128'(2));
    chk("t3_valid0", 128'(out_valid),    128'(0));
    chk("t3_allow",  128'(req_allow),    128'(1));
    req(32'h0003_0000);
    resp(32'h0002_0000, 1'b0);
    chk("t3_drop1", 128'(dut.drop_cnt), 128'(1));
    resp(32'h0002_0008, 1'b0);
    chk("t3_drop0", 128'(dut.drop_cnt), 128'(0));
    resp(32'h0003_0000, 1'b1);
    drain("t3_drain");
    chk("t3_drop_end", 128'(dut.drop_cnt), 128'(0));

    // 4: refill fault behind a bus request
    pop_en = 1'b0;
    req(32'h0005_0000);
    fault_fire = 1'b1; fault_refill = 1'b1; req_pc = 32'h0040_0000;
    tick();
    fault_fire = 1'b0; fault_refill = 1'b0;
    chk("t4_allow_fault", 128'(req_allow), 128'(0));
    resp(32'h0005_0000, 1'b1);
    exp_q.push_back('{pc: 32'h0040_0000, inst: 32'h0, inv: 1'b0, rf: 1'b1});
    chk("t4_allow_fault_head", 128'(req_allow), 128'(0));
    tick();
    chk("t4_allow_retired", 128'(req_allow), 128'(1));
    chk("t4_valid_pair",    128'(out_valid), 128'(2'b11));
    chk("t4_ref_pair",      128'(out_tlb_ref), 128'(2'b00));
    pop_en = 1'b1;
    tick();
    chk("t4_valid_fault", 128'(out_valid),   128'(2'b01));
    chk("t4_ref_fault",   128'(out_tlb_ref), 128'(2'b01));
    drain("t4_drain");

    // 5: fill to DEPTH without popping, across pointer wrap
    pop_en = 1'b0;
    req(32'h0006_0000);
    req(32'h0006_0008);
    chk("t5_allow_a", 128'(req_allow), 128'(0));
    resp(32'h0006_0000, 1'b1);
    chk("t5_allow_b", 128'(req_allow), 128'(1));
    req(32'h0006_0010);
    resp(32'h0006_0008, 1'b1);
    chk("t5_allow_c", 128'(req_allow), 128'(1));
    req(32'h0006_0018);
    resp(32'h0006_0010, 1'b1);
    chk("t5_allow_d", 128'(req_allow), 128'(0));
    resp(32'h0006_0018, 1'b1);
    chk("t5_full",    128'(dut.fifo_cnt), 128'(8));
    chk("t5_allow_e", 128'(req_allow),    128'(0));
    pop_en = 1'b1;
    tick();
    chk("t5_allow_pop", 128'(req_allow), 128'(1));
    drain("t5_drain");

    // 6: reset while a response and a pop are active
    req(32'h0007_0000);
    req(32'h0007_0008);
    resp(32'h0007_0000, 1'b1);
    reset   = 1'b0;
    data_ok = 1'b1;
    rdata   = {inst_of(32'h0007_000C), inst_of(32'h0007_0008)};
    tick();
    reset   = 1'b1;
    data_ok = 1'b0;
    chk("t6_valid", 128'(out_valid),      128'(0));
    chk("t6_allow", 128'(req_allow),      128'(1));
    chk("t6_drop",  128'(dut.drop_cnt),   128'(0));
    chk("t6_fifo",  128'(dut.fifo_cnt),   128'(0));
    req(32'h0008_0000);
    resp(32'h0008_0000, 1'b1);
    drain("t6_drain");

    chk("fifo_peak", 128'(max_fifo), 128'(8));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
